// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage definitions: PC-select encoding, the ID pipeline register, and fetch FSM states.
// Latency and backpressure: none, this file holds types and constants only.
package fetch_stage_pkg;

    typedef enum logic {
        NEXT_PC_SEL_PC_4    = 1'b0,
        NEXT_PC_SEL_ALU_OUT = 1'b1
    } next_pc_sel_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } pipeline_id_reg_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0: what ID sees in a reset or flushed slot
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_perf_cnt.sv
// Saturating event counters for the fetch stage: words fetched, responses killed, stall cycles.
// Latency: each count updates 1 cycle after its event. Backpressure: none, counts stick at all-ones.
module fetch_stage_perf_cnt (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetched_inc_i,
    input  logic        killed_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_killed_o,
    output logic [31:0] perf_stall_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_fetched_o <= '0;
            perf_killed_o  <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (fetched_inc_i && perf_fetched_o != '1) perf_fetched_o <= perf_fetched_o + 32'd1;
            if (killed_inc_i  && perf_killed_o  != '1) perf_killed_o  <= perf_killed_o  + 32'd1;
            if (stall_inc_i   && perf_stall_o   != '1) perf_stall_o   <= perf_stall_o   + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches from imem with one request in flight, and loads id_reg_o for ID. FETCH_PERF_CNT_EN adds counters.
// Latency: id_reg_o is valid 1 cycle after the imem response. Backpressure: stalls park the word in a 1-entry buffer and stop requesting.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  next_pc_sel_t     next_pc_sel_i,
    input  logic [31:0]      alu_out_i,
    input  logic             pc_reg_stall_i,
    input  logic             id_reg_stall_i,
    input  logic             id_reg_valid_i,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [31:0]      imem_rsp_data_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]      perf_fetched_o,
    output logic [31:0]      perf_killed_o,
    output logic [31:0]      perf_stall_o,
`endif
    output pipeline_id_reg_t id_reg_o
);

    fetch_state_t     state_q, state_nxt;
    logic [31:0]      pc_q, pc_nxt;
    pipeline_id_reg_t buf_q, buf_nxt;
    pipeline_id_reg_t id_nxt;
    pipeline_id_reg_t deliver_word;
    logic             deliver;
    logic             redirect;
    logic             accept;
    logic             stalled;
    logic [31:0]      redirect_pc;

    assign redirect    = (next_pc_sel_i == NEXT_PC_SEL_ALU_OUT);
    assign redirect_pc = alu_out_i & ~32'h3;
    assign stalled     = id_reg_stall_i || pc_reg_stall_i;

    // Request is masked during the reset cycle so imem never sees a stale PC.
    assign imem_req_valid_o = (state_q == S_REQ) && !reset_i;
    assign imem_addr_o      = pc_q;
    assign accept           = imem_req_valid_o && imem_req_ready_i;

    always_comb begin
        state_nxt          = state_q;
        pc_nxt             = pc_q;
        buf_nxt            = buf_q;
        deliver            = 1'b0;
        deliver_word.pc    = pc_q;
        deliver_word.instr = imem_rsp_data_i;
        deliver_word.valid = 1'b1;

        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = accept ? S_KILL : S_REQ;
                end else if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    buf_nxt.valid = 1'b0;
                    state_nxt     = imem_rsp_valid_i ? S_REQ : S_KILL;
                end else if (imem_rsp_valid_i) begin
                    if (!stalled) begin
                        deliver   = 1'b1;
                        pc_nxt    = pc_q + 32'd4;
                        state_nxt = S_REQ;
                    end else begin
                        buf_nxt.pc    = pc_q;
                        buf_nxt.instr = imem_rsp_data_i;
                        buf_nxt.valid = 1'b1;
                        state_nxt     = S_HOLD;
                    end
                end
            end
            S_KILL: begin
                if (redirect) pc_nxt = redirect_pc;
                if (imem_rsp_valid_i) state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt        = redirect_pc;
                    buf_nxt.valid = 1'b0;
                    state_nxt     = S_REQ;
                end else if (!stalled) begin
                    deliver            = 1'b1;
                    deliver_word.pc    = buf_q.pc;
                    deliver_word.instr = buf_q.instr;
                    pc_nxt             = pc_q + 32'd4;
                    buf_nxt.valid      = 1'b0;
                    state_nxt          = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase

        id_nxt = id_reg_o;
        if (deliver) begin
            id_nxt = deliver_word;
        end else if (!id_reg_stall_i) begin
            id_nxt.valid = 1'b0;
        end
        // Control flush and redirects override stalls and any word landing this cycle.
        if (redirect || !id_reg_valid_i) begin
            id_nxt.valid = 1'b0;
            id_nxt.instr = INSTR_NOP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            buf_q.pc       <= '0;
            buf_q.instr    <= INSTR_NOP;
            buf_q.valid    <= 1'b0;
            id_reg_o.pc    <= '0;
            id_reg_o.instr <= INSTR_NOP;
            id_reg_o.valid <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            pc_q     <= pc_nxt;
            buf_q    <= buf_nxt;
            id_reg_o <= id_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic killed_inc;
    logic stall_inc;

    assign killed_inc = imem_rsp_valid_i &&
                        ((state_q == S_KILL) || (state_q == S_WAIT && redirect));
    assign stall_inc  = (state_q == S_HOLD) || (state_q == S_WAIT);

    fetch_stage_perf_cnt u_perf_cnt (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetched_inc_i  (deliver),
        .killed_inc_i   (killed_inc),
        .stall_inc_i    (stall_inc),
        .perf_fetched_o (perf_fetched_o),
        .perf_killed_o  (perf_killed_o),
        .perf_stall_o   (perf_stall_o)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the imem handshake is driven cycle by cycle and results are checked against hand-computed values.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic             clk_i = 1'b0;
    logic             reset_i;
    next_pc_sel_t     next_pc_sel_i;
    logic [31:0]      alu_out_i;
    logic             pc_reg_stall_i;
    logic             id_reg_stall_i;
    logic             id_reg_valid_i;
    logic             imem_req_valid_o;
    logic             imem_req_ready_i;
    logic [31:0]      imem_addr_o;
    logic             imem_rsp_valid_i;
    logic [31:0]      imem_rsp_data_i;
    pipeline_id_reg_t id_reg_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      perf_fetched_o;
    logic [31:0]      perf_killed_o;
    logic [31:0]      perf_stall_o;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .next_pc_sel_i    (next_pc_sel_i),
        .alu_out_i        (alu_out_i),
        .pc_reg_stall_i   (pc_reg_stall_i),
        .id_reg_stall_i   (id_reg_stall_i),
        .id_reg_valid_i   (id_reg_valid_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched_o   (perf_fetched_o),
        .perf_killed_o    (perf_killed_o),
        .perf_stall_o     (perf_stall_o),
`endif
        .id_reg_o         (id_reg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle imem response carrying the given word
    task automatic rsp(input logic [31:0] data);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = data;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_vld"}, 32'(id_reg_o.valid), 32'd1);
        check({tag, "_pc"}, id_reg_o.pc, pc);
        check({tag, "_instr"}, id_reg_o.instr, instr);
    endtask

    initial begin
        reset_i          = 1'b1;
        next_pc_sel_i    = NEXT_PC_SEL_PC_4;
        alu_out_i        = '0;
        pc_reg_stall_i   = 1'b0;
        id_reg_stall_i   = 1'b0;
        id_reg_valid_i   = 1'b1;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;

        // Reset state
        tick();
        check("rst_req_vld", 32'(imem_req_valid_o), 32'd0);
        check("rst_id_vld", 32'(id_reg_o.valid), 32'd0);
        check("rst_id_pc", id_reg_o.pc, 32'd0);
        reset_i = 1'b0;
        #1;

        // Back-to-back fetches from RESET_PC with a 1-cycle imem
        check("t1_req_vld", 32'(imem_req_valid_o), 32'd1);
        check("t1_addr0", imem_addr_o, 32'h0001_0000);
        tick();
        check("t1_wait_noreq", 32'(imem_req_valid_o), 32'd0);
        rsp(32'hA000_0000);
        check_id("t1_id0", 32'h0001_0000, 32'hA000_0000);
        check("t1_addr1", imem_addr_o, 32'h0001_0004);
        tick();
        check("t1_bubble", 32'(id_reg_o.valid), 32'd0);
        rsp(32'hA000_0004);
        check_id("t1_id1", 32'h0001_0004, 32'hA000_0004);
        check("t1_addr2", imem_addr_o, 32'h0001_0008);

        // id_reg stall over 3 edges: word parks in the buffer, id_reg holds
        id_reg_stall_i = 1'b1;
        tick();
        check_id("t2_hold_a", 32'h0001_0004, 32'hA000_0004);
        rsp(32'hA000_0008);
        check("t2_hold_noreq", 32'(imem_req_valid_o), 32'd0);
        check_id("t2_hold_b", 32'h0001_0004, 32'hA000_0004);
        tick();
        check("t2_hold_noreq2", 32'(imem_req_valid_o), 32'd0);
        id_reg_stall_i = 1'b0;
        tick();
        check_id("t2_release", 32'h0001_0008, 32'hA000_0008);
        check("t2_addr", imem_addr_o, 32'h0001_000C);

        // Redirect in S_WAIT; late response must be dropped
        tick();
        next_pc_sel_i = NEXT_PC_SEL_ALU_OUT;
        alu_out_i     = 32'h0002_0000;
        tick();
        next_pc_sel_i = NEXT_PC_SEL_PC_4;
        check("t3_kill_noreq", 32'(imem_req_valid_o), 32'd0);
        check("t3_kill_id_vld", 32'(id_reg_o.valid), 32'd0);
        tick();
        check("t3_kill_noreq2", 32'(imem_req_valid_o), 32'd0);
        rsp(32'hDEAD_BEEF);
        check("t3_req_vld", 32'(imem_req_valid_o), 32'd1);
        check("t3_addr", imem_addr_o, 32'h0002_0000);
        check("t3_dropped", 32'(id_reg_o.valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t3_perf_killed", perf_killed_o, 32'd1);
`endif

        // Redirect in the same cycle as the response; low target bits ignored
        tick();
        next_pc_sel_i = NEXT_PC_SEL_ALU_OUT;
        alu_out_i     = 32'h0003_0002;
        rsp(32'hBAD0_0001);
        next_pc_sel_i = NEXT_PC_SEL_PC_4;
        check("t4_id_vld", 32'(id_reg_o.valid), 32'd0);
        check("t4_req_vld", 32'(imem_req_valid_o), 32'd1);
        check("t4_addr", imem_addr_o, 32'h0003_0000);
`ifdef FETCH_PERF_CNT_EN
        check("t4_perf_killed", perf_killed_o, 32'd2);
`endif

        // imem not ready for 5 cycles: request held steady
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_req_vld", 32'(imem_req_valid_o), 32'd1);
            check("t5_addr", imem_addr_o, 32'h0003_0000);
            check("t5_id_vld", 32'(id_reg_o.valid), 32'd0);
        end
        imem_req_ready_i = 1'b1;
        tick();
        rsp(32'hA003_0000);
        check_id("t5_id", 32'h0003_0000, 32'hA003_0000);

        // PC wraps from the top of the address space to 0
        imem_req_ready_i = 1'b0;
        next_pc_sel_i    = NEXT_PC_SEL_ALU_OUT;
        alu_out_i        = 32'hFFFF_FFFC;
        tick();
        next_pc_sel_i    = NEXT_PC_SEL_PC_4;
        imem_req_ready_i = 1'b1;
        check("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        rsp(32'hA0FF_FFFC);
        check_id("t6_id_top", 32'hFFFF_FFFC, 32'hA0FF_FFFC);
        check("t6_addr_wrap", imem_addr_o, 32'h0000_0000);

        // Reset in S_WAIT returns to RESET_PC
        tick();
        reset_i = 1'b1;
        #1;
        check("t6_rst_noreq", 32'(imem_req_valid_o), 32'd0);
        tick();
        reset_i = 1'b0;
        #1;
        check("t6_rst_addr", imem_addr_o, 32'h0001_0000);
        check("t6_rst_req", 32'(imem_req_valid_o), 32'd1);
        check("t6_rst_id_vld", 32'(id_reg_o.valid), 32'd0);

        // Flush clears id_reg even while id_reg is stalled
        tick();
        rsp(32'hA001_0000);
        check_id("t7_pre_flush", 32'h0001_0000, 32'hA001_0000);
        id_reg_valid_i = 1'b0;
        id_reg_stall_i = 1'b1;
        tick();
        id_reg_valid_i = 1'b1;
        id_reg_stall_i = 1'b0;
        check("t7_flushed", 32'(id_reg_o.valid), 32'd0);

        // PC stall on response parks the word, delivered once released
        pc_reg_stall_i = 1'b1;
        rsp(32'hA001_0004);
        check("t8_hold_noreq", 32'(imem_req_valid_o), 32'd0);
        check("t8_hold_id_vld", 32'(id_reg_o.valid), 32'd0);
        pc_reg_stall_i = 1'b0;
        tick();
        check_id("t8_release", 32'h0001_0004, 32'hA001_0004);
        check("t8_addr", imem_addr_o, 32'h0001_0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
